// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port framebuffer RAM between three requesters, one RAM
// access per clock:
//   1. display read  (phase 0 of each visible pixel period)
//   2. clear fill    (whole framebuffer, one word per free slot)
//   3. draw write    (draw engine, one word per grant)
// The display read returns one clock later; the color is registered into rgb
// at the end of phase 1, so it is stable from phase 2 of the pixel through
// phase 1 of the following pixel.
//
// Handshake: wr_req/wr_addr/wr_data are held by the draw engine until wr_ack.
// wr_ack is a combinational one-cycle grant; the word is consumed in the same
// cycle. Out-of-range addresses are acknowledged but never written.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   p_tick, vid_on      pixel enable (1 clk in 4) and display-active flag
//   pixel_x, pixel_y    current beam position (screen pixels)
//   wr_req/addr/data    draw-engine write request, wr_ack grant
//   clr_start/color     start a framebuffer fill, clr_busy while filling
//   mem_addr/we/din     RAM request (combinational), mem_dout read data
//   rgb                 registered pixel color to the DAC
//   dbg_state           current arbiter FSM state (0 = idle, 1 = clearing)
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int FB_DEPTH = 19200,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_tick,
    input  logic          vid_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          wr_req,
    input  logic [14:0]   wr_addr,
    input  logic [CW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clr_start,
    input  logic [CW-1:0] clr_color,
    output logic          clr_busy,
    output logic [14:0]   mem_addr,
    output logic          mem_we,
    output logic [CW-1:0] mem_din,
    input  logic [CW-1:0] mem_dout,
    output logic [CW-1:0] rgb,
    output logic          dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [14:0] FB_W_W    = 15'(FB_W);
    localparam logic [14:0] DEPTH_W   = 15'(FB_DEPTH);
    // Last fill address; FB_W*FB_H and FB_DEPTH describe the same size.
    localparam logic [14:0] LAST_ADDR = 15'(FB_W * FB_H - 1);

    logic [1:0]    phase_q, phase_d;
    logic          synced_q, synced_d;     // a p_tick has been seen since reset
    state_t        state_q, state_d;
    logic [14:0]   clr_ptr_q, clr_ptr_d;
    logic [CW-1:0] clr_col_q, clr_col_d;
    logic          disp_pend_q, disp_pend_d; // display read issued last clk
    logic [CW-1:0] rgb_q, rgb_d;

    logic          disp_slot;
    logic [14:0]   row_idx, col_idx, disp_addr;

    // One framebuffer word covers a 4x4 block of screen pixels.
    assign row_idx   = 15'(pixel_y >> 2);
    assign col_idx   = 15'(pixel_x >> 2);
    assign disp_addr = row_idx * FB_W_W + col_idx;

    // Until the first p_tick the phase counter is not aligned to the pixel
    // period, so display reads wait for it.
    assign disp_slot = reset && synced_q && vid_on && (phase_q == 2'd0);

    always_comb begin
        phase_d     = p_tick ? 2'd0 : phase_q + 2'd1;
        synced_d    = synced_q | p_tick;
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_col_d   = clr_col_q;
        disp_pend_d = disp_slot;
        rgb_d       = rgb_q;
        wr_ack      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;

        // Read data of the phase-0 display read is on mem_dout in phase 1.
        if (disp_pend_q) begin
            rgb_d = mem_dout;
        end else if (phase_q == 2'd1 && !vid_on) begin
            rgb_d = '0;
        end

        // Combinational grants are suppressed while reset is asserted.
        if (reset) begin
            if (disp_slot) begin
                mem_addr = disp_addr;
            end
            case (state_q)
                S_IDLE: begin
                    if (clr_start) begin
                        // Fill wins over a simultaneous draw; the draw stays pending.
                        state_d   = S_CLEAR;
                        clr_ptr_d = '0;
                        clr_col_d = clr_color;
                    end else if (wr_req && !disp_slot) begin
                        wr_ack = 1'b1;
                        if (wr_addr < DEPTH_W) begin
                            mem_we   = 1'b1;
                            mem_addr = wr_addr;
                            mem_din  = wr_data;
                        end
                    end
                end
                S_CLEAR: begin
                    if (!disp_slot) begin
                        mem_we    = 1'b1;
                        mem_addr  = clr_ptr_q;
                        mem_din   = clr_col_q;
                        clr_ptr_d = clr_ptr_q + 15'd1;
                        if (clr_ptr_q == LAST_ADDR) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q     <= 2'd0;
            synced_q    <= 1'b0;
            state_q     <= S_IDLE;
            clr_ptr_q   <= '0;
            clr_col_q   <= '0;
            disp_pend_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            phase_q     <= phase_d;
            synced_q    <= synced_d;
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_col_q   <= clr_col_d;
            disp_pend_q <= disp_pend_d;
            rgb_q       <= rgb_d;
        end
    end

    assign clr_busy  = (state_q == S_CLEAR);
    assign rgb       = rgb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Environment: a behavioural single-port RAM (1-clk read latency), a beam
// generator standing in for the sync block (p_tick 1 clk in 4, beam position
// and vid_on updated at each pixel boundary), and driver tasks for draw writes
// and fills. A negedge monitor holds a reference model of the framebuffer,
// the fill progress and the expected draw grants, and compares every cycle.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int DEPTH = 19200;
    localparam int CW    = 12;

    logic          clk;
    logic          reset;
    logic          p_tick;
    logic          vid_on;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          wr_req;
    logic [14:0]   wr_addr;
    logic [CW-1:0] wr_data;
    logic          wr_ack;
    logic          clr_start;
    logic [CW-1:0] clr_color;
    logic          clr_busy;
    logic [14:0]   mem_addr;
    logic          mem_we;
    logic [CW-1:0] mem_din;
    logic [CW-1:0] mem_dout;
    logic [CW-1:0] rgb;
    logic          dbg_state;

    vram_arbiter #(
        .FB_W(FB_W), .FB_H(FB_H), .FB_DEPTH(DEPTH), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .vid_on(vid_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout), .rgb(rgb), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [CW-1:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_we && mem_addr < 15'(DEPTH)) ram[mem_addr] <= mem_din;
        if (mem_addr < 15'(DEPTH)) mem_dout <= ram[mem_addr];
    end

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- beam / sync generator ----------------
    int cnt;          // position inside pixel period, 0 = first clk
    bit synced;       // a p_tick has occurred since reset release
    int beam_mode;    // 0 blanking, 1 fixed pixel, 2 random mix
    int fx, fy;

    initial begin
        cnt = 0; synced = 0; p_tick = 0;
        vid_on = 0; pixel_x = 10'd700; pixel_y = 10'd500;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                cnt = 0; synced = 0; p_tick = 0;
            end else begin
                if (p_tick) synced = 1;
                cnt    = (cnt + 1) % 4;
                p_tick = (cnt == 3);
                if (cnt == 0) begin
                    if (beam_mode == 1) begin
                        vid_on = 1; pixel_x = 10'(fx); pixel_y = 10'(fy);
                    end else if (beam_mode == 2 && $urandom_range(0, 3) != 0) begin
                        vid_on  = 1;
                        pixel_x = 10'($urandom_range(0, 639));
                        pixel_y = 10'($urandom_range(0, 479));
                    end else begin
                        vid_on = 0; pixel_x = 10'd700; pixel_y = 10'd500;
                    end
                end
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    logic [CW-1:0] model_fb [0:DEPTH-1];
    logic [26:0]   exp_q[$];      // {addr[14:0], data[11:0]} of pending draws
    logic [CW-1:0] disp_q[$];     // colors expected on rgb at phase 2
    int            m_clearing, m_ptr;
    logic [CW-1:0] m_color;
    bit            hold_valid;
    logic [CW-1:0] hold_color;
    int            clr_writes, we_count, last_ack_cnt;

    initial begin
        bit            slot_disp, clr_slot, grant, accept_clr;
        int            a;
        logic [26:0]   e;
        logic [CW-1:0] c;
        m_clearing = 0; m_ptr = 0; m_color = '0; hold_valid = 0; hold_color = '0;
        clr_writes = 0; we_count = 0; last_ack_cnt = -1;
        for (int i = 0; i < DEPTH; i++) model_fb[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_clearing = 0; m_ptr = 0; hold_valid = 0;
                exp_q.delete(); disp_q.delete();
                continue;
            end
            slot_disp  = (cnt == 0) && vid_on && synced;
            clr_slot   = (m_clearing != 0) && !slot_disp;
            accept_clr = clr_start && (m_clearing == 0);
            grant      = wr_req && (m_clearing == 0) && !slot_disp && !clr_start;
            chk("clr_busy", clr_busy, m_clearing);
            chk("wr_ack", wr_ack, grant);
            if (mem_we) we_count++;

            if (slot_disp) begin
                a = (int'(pixel_y) / 4) * FB_W + int'(pixel_x) / 4;
                chk("disp_we", mem_we, 0);
                chk("disp_addr", mem_addr, a);
                disp_q.push_back(model_fb[a]);
            end else if (clr_slot) begin
                chk("clr_we", mem_we, 1);
                chk("clr_addr", mem_addr, m_ptr);
                chk("clr_din", mem_din, m_color);
                model_fb[m_ptr] = m_color;
                clr_writes++;
                if (m_ptr == DEPTH - 1) m_clearing = 0;
                m_ptr++;
            end else if (grant && wr_ack) begin
                last_ack_cnt = cnt;
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(e[26:12]) < DEPTH) begin
                        chk("draw_we", mem_we, 1);
                        chk("draw_addr", mem_addr, e[26:12]);
                        chk("draw_din", mem_din, e[11:0]);
                        model_fb[int'(e[26:12])] = e[11:0];
                    end else begin
                        chk("draw_oob_we", mem_we, 0);
                    end
                end
            end else begin
                chk("idle_bus", {mem_we, mem_addr, mem_din}, 0);
            end

            if (accept_clr) begin
                m_clearing = 1; m_ptr = 0; m_color = clr_color;
            end

            // rgb: new color at phase 2, held through phase 1 of next pixel.
            if (cnt == 2) begin
                if (disp_q.size() > 0) begin
                    c = disp_q.pop_front();
                    chk("rgb_pixel", rgb, c);
                    hold_valid = 1; hold_color = c;
                end else if (!vid_on) begin
                    chk("rgb_blank", rgb, 0);
                    hold_valid = 1; hold_color = '0;
                end else begin
                    hold_valid = 0;
                end
            end else if (hold_valid) begin
                chk("rgb_hold", rgb, hold_color);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("ack_timeout", 0, 1);
            exp_q.delete();
        end
        @(posedge clk);
        #2;
        wr_req = 0;
    endtask

    task automatic draw(input logic [14:0] a, input logic [CW-1:0] d,
                        input bit align, output bit ok);
        if (align) begin
            for (int i = 0; i < 64; i++) begin
                @(posedge clk);
                #2;
                if (cnt == 0 && synced && vid_on) break;
            end
        end else begin
            @(posedge clk);
            #2;
        end
        wr_req = 1; wr_addr = a; wr_data = d;
        exp_q.push_back({a, d});
        wait_ack(50, ok);
    endtask

    task automatic start_clear(input logic [CW-1:0] color);
        @(posedge clk);
        #2;
        clr_start = 1; clr_color = color;
        @(posedge clk);
        #2;
        clr_start = 0;
    endtask

    task automatic wait_clear_done(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!clr_busy) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("clear_timeout", 0, 1);
    endtask

    function automatic int count_diff_const(input logic [CW-1:0] v);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== v) bad++;
        return bad;
    endfunction

    function automatic int count_diff_model();
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_fb[i]) bad++;
        return bad;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #10ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int base, we_base;
        logic [14:0] ra;
        reset = 0; beam_mode = 0; fx = 0; fy = 0;
        clr_start = 0; clr_color = '0;
        wr_req = 1; wr_addr = 15'd5; wr_data = 12'h111;  // must not be granted in reset

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb", rgb, 0);
        chk("reset_busy", clr_busy, 0);
        chk("reset_ack", wr_ack, 0);
        chk("reset_we", mem_we, 0);
        wr_req = 0;
        reset = 1;

        // full fill during blanking; a second clr_start mid-fill is ignored
        repeat (10) @(posedge clk);
        base = clr_writes;
        start_clear(12'h0F0);
        repeat (100) @(posedge clk);
        start_clear(12'h555);
        wait_clear_done(25000);
        chk("clr_write_count", clr_writes - base, DEPTH);
        chk("ram_fill", count_diff_const(12'h0F0), 0);

        // preload word 161, then show beam pixel (4,4)
        draw(15'd161, 12'hABC, 0, ok);
        fx = 4; fy = 4; beam_mode = 1;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cnt == 2) break;
        end
        chk("rgb_x4y4", rgb, 12'hABC);

        // draw raised in a display slot is granted in phase 1
        draw(15'h0100, 12'hF00, 1, ok);
        chk("ack_phase", last_ack_cnt, 1);

        // random draws under random active video / blanking
        beam_mode = 2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) ra = 15'($urandom_range(DEPTH, 32767));
            else ra = 15'($urandom_range(0, DEPTH - 1));
            draw(ra, 12'($urandom), 0, ok);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // out-of-range draw: acknowledged, RAM untouched
        draw(15'd19200, 12'h3C3, 0, ok);
        chk("oob_ack", ok, 1);
        repeat (2) @(posedge clk);
        chk("ram_after_oob", count_diff_model(), 0);

        // fill and draw in the same clk: fill first, draw after it
        beam_mode = 0;
        repeat (8) @(posedge clk);
        @(posedge clk);
        #2;
        clr_start = 1; clr_color = 12'h00F;
        wr_req = 1; wr_addr = 15'd50; wr_data = 12'h123;
        exp_q.push_back({15'd50, 12'h123});
        @(negedge clk);
        chk("same_clk_ack", wr_ack, 0);
        @(posedge clk);
        #2;
        clr_start = 0;
        @(negedge clk);
        chk("same_clk_busy", clr_busy, 1);
        wait_ack(25000, ok);
        chk("ack_after_fill", clr_busy, 0);
        repeat (2) @(posedge clk);
        chk("ram_50", ram[50], 12'h123);
        chk("ram_51", ram[51], 12'h00F);

        // reset in the middle of a fill under active video
        beam_mode = 2;
        start_clear(12'h777);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            if (m_ptr == 5000) break;
        end
        chk("reached_5000", m_ptr, 5000);
        wr_req = 1; wr_addr = 15'd7; wr_data = 12'h999;
        reset = 0;
        #1;
        chk("rst_busy", clr_busy, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ack", wr_ack, 0);
        wr_req = 0;
        repeat (2) @(posedge clk);
        we_base = we_count;
        @(negedge clk);
        reset = 1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("post_reset_writes", we_count - we_base, 0);
        chk("ram_4999", ram[4999], 12'h777);
        chk("ram_5000", ram[5000], 12'h00F);
        chk("ram_final", count_diff_model(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FB_W, default 160, framebuffer width in words (one word per 4x4 screen pixels).
REQ-002 Parameter FB_H, default 120, framebuffer height in words.
REQ-003 Parameter FB_DEPTH, default 19200, framebuffer depth; SHALL equal FB_W*FB_H.
REQ-004 Parameter CW, default 12, color word width.
REQ-005 clk  in  1  system clock, 100 MHz.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 p_tick  in  1  pixel-clock enable from sync block, high 1 clk in every 4.
REQ-008 vid_on  in  1  display-active flag from sync block.
REQ-009 pixel_x  in  10  current beam column, 0..799.
REQ-010 pixel_y  in  10  current beam row, 0..524.
REQ-011 wr_req  in  1  draw-engine write request; addr/data held stable until wr_ack.
REQ-012 wr_addr  in  15  draw-engine framebuffer address.
REQ-013 wr_data  in  CW  draw-engine write color.
REQ-014 wr_ack  out  1  one-cycle grant; write consumed this cycle.
REQ-015 clr_start  in  1  one-cycle pulse: fill framebuffer with clr_color.
REQ-016 clr_color  in  CW  fill color, sampled on accepted clr_start.
REQ-017 clr_busy  out  1  high while fill in progress.
REQ-018 mem_addr  out  15  single-port RAM address (combinational).
REQ-019 mem_we  out  1  RAM write enable (combinational).
REQ-020 mem_din  out  CW  RAM write data (combinational).
REQ-021 mem_dout  in  CW  RAM read data, valid 1 clk after read address presented.
REQ-022 rgb  out  CW  registered pixel color to DAC.

Function
REQ-023 Phase counter (2 bits): cleared to 0 on the clk after p_tick, else increments with wrap; phase 0 = first clk of each pixel period.
REQ-024 Slot priority each clk: display read > clear write > draw write; exactly one RAM access per clk.
REQ-025 Display slot: phase==0 and vid_on; mem_we=0, mem_addr=(pixel_y>>2)*FB_W+(pixel_x>>2), computed at 15 bits, no truncation for x<640, y<480.
REQ-026 Display read registered flag disp_d set in phase 0 slot; at end of next clk (phase 1) rgb <= mem_dout; at phase 1 with disp_d=0 and vid_on=0, rgb <= 0.
REQ-027 rgb latency: color for pixel (x,y) valid from phase 2 of that pixel through phase 1 of the next pixel.
REQ-028 FSM states IDLE, CLEAR; IDLE->CLEAR on clr_start (clr_ptr<=0, color latched); clr_start ignored in CLEAR.
REQ-029 CLEAR: every non-display slot, mem_we=1, mem_addr=clr_ptr, mem_din=latched color, clr_ptr++; write at clr_ptr==FB_DEPTH-1 -> IDLE next clk.
REQ-030 clr_busy=1 exactly in CLEAR; wr_ack held 0 throughout CLEAR.
REQ-031 Draw slot: IDLE, non-display slot, wr_req=1 -> wr_ack=1, mem_we=1, mem_addr=wr_addr, mem_din=wr_data, same clk.
REQ-032 wr_addr>=FB_DEPTH: wr_ack=1 (request consumed), mem_we=0.
REQ-033 Blanking (vid_on=0): all 4 phases available to clear/draw.
REQ-034 clr_start and wr_req same clk in IDLE: clear wins; wr_req stays pending, not acked.
REQ-035 Idle slot (no requester): mem_we=0, mem_addr=0, mem_din=0.

Reset
REQ-036 reset=0 asynchronously forces: phase=0, FSM=IDLE, clr_ptr=0, disp_d=0, rgb=0, clr_busy=0, wr_ack=0, mem_we=0.
REQ-037 Reset mid-CLEAR aborts fill; no further writes; framebuffer contents not restored.
REQ-038 First display read after reset release occurs only after first p_tick.

Verification
REQ-039 Active video, wr_req held, addr 0x0100, data 0xF00 -> wr_ack in phase 1, mem_we=1 same clk, never in phase 0.
REQ-040 Preload RAM[161]=0xABC, beam x=4,y=4 -> mem_addr=161 phase 0, rgb=0xABC from phase 2.
REQ-041 clr_start, clr_color=0x0F0 during blanking-only stimulus -> 19200 writes addr 0..19199, clr_busy drops 1 clk after last; all RAM=0x0F0.
REQ-042 wr_req with wr_addr=19200 -> wr_ack=1, mem_we=0, RAM unchanged.
REQ-043 reset=0 at clr_ptr=5000 -> clr_busy=0, rgb=0 immediately; no writes after release.
REQ-044 clr_start and wr_req same clk -> clr_busy=1, wr_ack=0 until fill done, then draw write acked.
